// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath width, register-address width
// and the write-back source select encoding.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM bundle into the memory stage and the write-back port it drives.
// The master side is the upstream pipeline; the slave side is mem_wb_stage.
interface mem_wb_stage_if #(parameter int DATA_W = mips_pkg::DATA_W);

    logic                        EXMEMvalid;
    logic [DATA_W-1:0]           EXMEMAluResult;
    logic [DATA_W-1:0]           EXMEMwriteDataMem;
    logic [mips_pkg::REG_AW-1:0] EXMEMRt;
    logic [mips_pkg::REG_AW-1:0] EXMEMwritereg;
    logic                        EXMEMWriteRegEnable;
    logic                        EXMEMWriteMemoryEnable;
    logic                        EXMEMReadMemoryEnable;
    logic                        EXMEMwritebackRegCtrl;
    logic                        stall;
    logic                        flush;

    logic [DATA_W-1:0]           writeData;
    logic [mips_pkg::REG_AW-1:0] MemWBwritereg;
    logic                        WriteRegEnable;
    logic                        MemWBvalid;

    modport master (
        output EXMEMvalid, EXMEMAluResult, EXMEMwriteDataMem, EXMEMRt, EXMEMwritereg,
               EXMEMWriteRegEnable, EXMEMWriteMemoryEnable, EXMEMReadMemoryEnable,
               EXMEMwritebackRegCtrl, stall, flush,
        input  writeData, MemWBwritereg, WriteRegEnable, MemWBvalid
    );

    modport slave (
        input  EXMEMvalid, EXMEMAluResult, EXMEMwriteDataMem, EXMEMRt, EXMEMwritereg,
               EXMEMWriteRegEnable, EXMEMWriteMemoryEnable, EXMEMReadMemoryEnable,
               EXMEMwritebackRegCtrl, stall, flush,
        output writeData, MemWBwritereg, WriteRegEnable, MemWBvalid
    );

endinterface

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, asynchronous read.
// Not reset; contents are whatever the simulator or FPGA init provides.
module data_memory #(
    parameter int DATA_W = 32,
    parameter int AW     = 8,
    parameter int DEPTH  = 1 << AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access / write-back stage: data memory plus MEM/WB register.
// Define WB_STORE_FWD_EN to forward write-back data into a dependent store.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DMEM_DEPTH = 256,
    parameter int DMEM_AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);

    logic [DMEM_AW-1:0] word_idx;
    logic               store_en;
    logic [DATA_W-1:0]  store_data;
    logic [DATA_W-1:0]  load_data;

    logic               wb_valid;
    logic               wb_rwe;
    reg_addr_t          wb_reg;
    logic               wb_sel;
    logic [DATA_W-1:0]  wb_alu;
    logic [DATA_W-1:0]  wb_load;

    logic [DATA_W-1:0]  wb_data;
    logic               wb_en;
    logic               unused_ok;

    // Byte offset bits are ignored and high bits fall off, so addresses wrap.
    assign word_idx = bus.EXMEMAluResult[DMEM_AW+1:2];

    assign store_en = rst_n & bus.EXMEMvalid & bus.EXMEMWriteMemoryEnable
                    & ~bus.stall & ~bus.flush;

`ifdef WB_STORE_FWD_EN
    assign store_data = (wb_en && (wb_reg == bus.EXMEMRt) && bus.EXMEMWriteMemoryEnable)
                      ? wb_data : bus.EXMEMwriteDataMem;
    assign unused_ok  = bus.EXMEMReadMemoryEnable;
`else
    assign store_data = bus.EXMEMwriteDataMem;
    assign unused_ok  = ^{bus.EXMEMReadMemoryEnable, bus.EXMEMRt};
`endif

    data_memory #(
        .DATA_W (DATA_W),
        .AW     (DMEM_AW),
        .DEPTH  (DMEM_DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (store_en),
        .addr  (word_idx),
        .wdata (store_data),
        .rdata (load_data)
    );

    // Flush only kills the slot; the data fields keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
            wb_reg   <= '0;
            wb_sel   <= WB_SEL_ALU;
            wb_alu   <= '0;
            wb_load  <= '0;
        end else if (bus.flush) begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
        end else if (!bus.stall) begin
            wb_valid <= bus.EXMEMvalid;
            wb_rwe   <= bus.EXMEMWriteRegEnable & bus.EXMEMvalid;
            wb_reg   <= bus.EXMEMwritereg;
            wb_sel   <= bus.EXMEMwritebackRegCtrl;
            wb_alu   <= bus.EXMEMAluResult;
            wb_load  <= load_data;
        end
    end

    // Register $0 is hard-wired to zero, so it never gets a write strobe.
    assign wb_data = (wb_sel == WB_SEL_MEM) ? wb_load : wb_alu;
    assign wb_en   = wb_rwe & wb_valid & (wb_reg != '0);

    assign bus.writeData      = wb_data;
    assign bus.MemWBwritereg  = wb_reg;
    assign bus.WriteRegEnable = wb_en;
    assign bus.MemWBvalid     = wb_valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases followed by random
// traffic, all compared against a word-array memory and slot model.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .DATA_W     (32),
        .DMEM_DEPTH (DEPTH),
        .DMEM_AW    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference: what each memory word holds, and what write-back shows now.
    logic [31:0] ref_mem [DEPTH];
    bit          m_valid;
    bit          m_rwe;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    function automatic bit m_we();
        return m_valid && m_rwe && (m_reg != 5'd0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.MemWBvalid), 32'(m_valid));
        checkOutput({tag, "_we"},    32'(bus.WriteRegEnable), 32'(m_we()));
        checkOutput({tag, "_reg"},   32'(bus.MemWBwritereg), 32'(m_reg));
        checkOutput({tag, "_data"},  bus.writeData, m_data);
    endtask

    // Drives one EX/MEM slot, advances one clock edge and updates the model.
    task automatic applyStimulus(input bit valid, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rt, input logic [4:0] wreg, input bit rwe,
                                 input bit wme, input bit rme, input bit wbsel,
                                 input bit stall, input bit flush);
        int          idx;
        logic [31:0] sdata;
        logic [31:0] loaded;
        bus.EXMEMvalid             = valid;
        bus.EXMEMAluResult         = addr;
        bus.EXMEMwriteDataMem      = wdata;
        bus.EXMEMRt                = rt;
        bus.EXMEMwritereg          = wreg;
        bus.EXMEMWriteRegEnable    = rwe;
        bus.EXMEMWriteMemoryEnable = wme;
        bus.EXMEMReadMemoryEnable  = rme;
        bus.EXMEMwritebackRegCtrl  = wbsel;
        bus.stall                  = stall;
        bus.flush                  = flush;
        idx    = int'((addr / 4) % DEPTH);
        loaded = ref_mem[idx];
        sdata  = wdata;
`ifdef WB_STORE_FWD_EN
        if (m_we() && m_reg == rt && wme) sdata = m_data;
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_rwe = 0; m_reg = 0; m_data = 0;
        end else begin
            if (valid && wme && !stall && !flush) ref_mem[idx] = sdata;
            if (flush) begin
                m_valid = 0;
                m_rwe   = 0;
            end else if (!stall) begin
                m_valid = valid;
                m_rwe   = rwe && valid;
                m_reg   = wreg;
                m_data  = wbsel ? loaded : addr;
            end
        end
        #1;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1, addr, data, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [4:0] wreg);
        applyStimulus(1, addr, 32'h0, 5'd0, wreg, 1, 0, 1, 1, 0, 0);
    endtask

    task automatic doAlu(input logic [31:0] res, input logic [4:0] wreg);
        applyStimulus(1, res, 32'h0, 5'd0, wreg, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        m_valid = 0; m_rwe = 0; m_reg = 0; m_data = 0;
        bus.EXMEMvalid = 0; bus.EXMEMAluResult = 0; bus.EXMEMwriteDataMem = 0;
        bus.EXMEMRt = 0; bus.EXMEMwritereg = 0; bus.EXMEMWriteRegEnable = 0;
        bus.EXMEMWriteMemoryEnable = 0; bus.EXMEMReadMemoryEnable = 0;
        bus.EXMEMwritebackRegCtrl = 0; bus.stall = 0; bus.flush = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.MemWBvalid), 32'h0);
        checkOutput("rst_we",    32'(bus.WriteRegEnable), 32'h0);
        checkOutput("rst_reg",   32'(bus.MemWBwritereg), 32'h0);
        checkOutput("rst_data",  bus.writeData, 32'h0);
        #2 rst_n = 1'b1;
        #2;

        // Memory is not reset, so give every word a known value first.
        for (int i = 0; i < DEPTH; i++) doStore(32'(i * 4), 32'h0);

        doStore(32'h10, 32'h55);
        rst_n = 1'b0;
        applyStimulus(1, 32'h10, 32'hBAD, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0);
        checkAll("rst_mid");
        #2 rst_n = 1'b1;
        #1;
        doLoad(32'h10, 5'd1);
        checkOutput("rst_drop_data", bus.writeData, 32'h55);
        checkAll("rst_drop");

        doStore(32'h20, 32'hDEADBEEF);
        doLoad(32'h20, 5'd8);
        checkOutput("ld_data", bus.writeData, 32'hDEADBEEF);
        checkOutput("ld_reg",  32'(bus.MemWBwritereg), 32'd8);
        checkOutput("ld_we",   32'(bus.WriteRegEnable), 32'd1);

        doAlu(32'h7, 5'd3);
        checkOutput("rtype_data", bus.writeData, 32'h7);
        checkOutput("rtype_we",   32'(bus.WriteRegEnable), 32'd1);
        doAlu(32'h7, 5'd0);
        checkOutput("rtype_r0_we", 32'(bus.WriteRegEnable), 32'd0);

        doAlu(32'h99, 5'd4);
        applyStimulus(1, 32'h20, 32'hAAAA, 5'd0, 5'd0, 0, 1, 0, 0, 1, 0);
        checkOutput("stall_hold_data", bus.writeData, 32'h99);
        checkOutput("stall_hold_reg",  32'(bus.MemWBwritereg), 32'd4);
        checkAll("stall");
        doLoad(32'h20, 5'd9);
        checkOutput("stall_nostore", bus.writeData, 32'hDEADBEEF);
        applyStimulus(1, 32'h20, 32'h0, 5'd0, 5'd10, 1, 0, 1, 1, 0, 1);
        checkOutput("flush_valid", 32'(bus.MemWBvalid), 32'd0);
        checkOutput("flush_we",    32'(bus.WriteRegEnable), 32'd0);
        doAlu(32'h5, 5'd11);
        applyStimulus(1, 32'h6, 32'h0, 5'd0, 5'd12, 1, 0, 0, 0, 1, 1);
        checkOutput("stall_flush_valid", 32'(bus.MemWBvalid), 32'd0);
        checkAll("stall_flush");

        doStore(32'(4 * DEPTH + 8), 32'h11223344);
        doLoad(32'h8, 5'd2);
        checkOutput("wrap_data", bus.writeData, 32'h11223344);
        doStore(32'h21, 32'h77);
        doLoad(32'h20, 5'd2);
        checkOutput("unaligned_data", bus.writeData, 32'h77);

        doStore(32'h40, 32'h1234);
        doLoad(32'h40, 5'd5);
        applyStimulus(1, 32'h44, 32'h0, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0);
        doLoad(32'h44, 5'd6);
`ifdef WB_STORE_FWD_EN
        checkOutput("fwd_store", bus.writeData, 32'h1234);
`else
        checkOutput("fwd_store", bus.writeData, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            int          op;
            logic [31:0] addr;
            op   = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            applyStimulus(op != 3, addr, $urandom, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), op <= 1, op == 2, op == 1, op == 1,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            checkAll("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
